glb_port_arbiter: RTL and testbench

- Shares the single physical GLB SRAM port among four NoC-controller streams: ifmap read, filter read, ipsum read and opsum write.
- Round-robin arbitration, one access per cycle.
- Registered SRAM-side outputs. Read data is returned tagged to the issuing requester after a fixed latency.
- Sits between NoC_Controller's per-stream GLB request/address outputs and the GLB macro. Exposes busy so the pass controller can detect drain before declaring a pass done.

---
 rtl/glb_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_glb_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_port_arbiter.sv
// -----------------------------------------------------------------------------
// glb_port_arbiter
//
// Shares the single GLB SRAM port among four NoC-controller streams using
// round-robin arbitration, one access per cycle. SRAM-side outputs are
// registered. Read data returns on a shared bus, tagged with a per-stream
// rvalid pulse, RD_LATENCY+2 cycles after the grant.
//
// Requester indices: 0 ifmap, 1 filter, 2 ipsum, 3 opsum (write only).
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   <s>_req / <s>_addr         level request held until granted, address
//   opsum_wdata                opsum write data
//   <s>_gnt                    request accepted this cycle (combinational)
//   <s>_rvalid                 rdata belongs to stream <s> this cycle
//   rdata                      shared registered read-return bus
//   glb_en/we/addr/wdata       registered SRAM command
//   glb_rdata                  SRAM read data
//   busy                       access issued or read still in flight
// -----------------------------------------------------------------------------
module glb_port_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ifmap_req,
    input  logic [ADDR_WIDTH-1:0] ifmap_addr,
    output logic                  ifmap_gnt,
    output logic                  ifmap_rvalid,

    input  logic                  filter_req,
    input  logic [ADDR_WIDTH-1:0] filter_addr,
    output logic                  filter_gnt,
    output logic                  filter_rvalid,

    input  logic                  ipsum_req,
    input  logic [ADDR_WIDTH-1:0] ipsum_addr,
    output logic                  ipsum_gnt,
    output logic                  ipsum_rvalid,

    input  logic                  opsum_req,
    input  logic [ADDR_WIDTH-1:0] opsum_addr,
    input  logic [DATA_WIDTH-1:0] opsum_wdata,
    output logic                  opsum_gnt,

    output logic [DATA_WIDTH-1:0] rdata,

    output logic                  glb_en,
    output logic                  glb_we,
    output logic [ADDR_WIDTH-1:0] glb_addr,
    output logic [DATA_WIDTH-1:0] glb_wdata,
    input  logic [DATA_WIDTH-1:0] glb_rdata,

    output logic                  busy
);

    localparam int NSTG = RD_LATENCY + 1;
    localparam logic [1:0] ID_OPSUM = 2'd3;

    logic [1:0]            ptr;
    logic [3:0]            req_vec;
    logic [3:0]            gnt_vec;
    logic [1:0]            win;
    logic [1:0]            scan_idx;
    logic                  any_req;
    logic                  gnt_ok;
    logic [ADDR_WIDTH-1:0] sel_addr;

    logic [NSTG-1:0]       pipe_vld;
    logic [1:0]            pipe_id [NSTG];
    logic [3:0]            rvalid_q;

    assign req_vec = {opsum_req, ipsum_req, filter_req, ifmap_req};

    // Scan offsets from highest to lowest so the requester nearest to ptr
    // (offset 0 upward) is the last one written and therefore wins.
    always_comb begin
        win      = 2'd0;
        any_req  = 1'b0;
        scan_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            scan_idx = ptr + 2'(i);
            if (req_vec[scan_idx]) begin
                win     = scan_idx;
                any_req = 1'b1;
            end
        end
    end

    // Requests seen while reset is high are not accepted.
    assign gnt_ok = any_req && !reset;

    always_comb begin
        gnt_vec = 4'b0000;
        if (gnt_ok) begin
            gnt_vec[win] = 1'b1;
        end
    end

    assign ifmap_gnt  = gnt_vec[0];
    assign filter_gnt = gnt_vec[1];
    assign ipsum_gnt  = gnt_vec[2];
    assign opsum_gnt  = gnt_vec[3];

    always_comb begin
        sel_addr = ifmap_addr;
        case (win)
            2'd1:    sel_addr = filter_addr;
            2'd2:    sel_addr = ipsum_addr;
            2'd3:    sel_addr = opsum_addr;
            default: sel_addr = ifmap_addr;
        endcase
    end

    // SRAM command issue and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= 2'd0;
            glb_en    <= 1'b0;
            glb_we    <= 1'b0;
            glb_addr  <= '0;
            glb_wdata <= '0;
        end else begin
            glb_en <= gnt_ok;
            glb_we <= gnt_ok && (win == ID_OPSUM);
            if (gnt_ok) begin
                ptr      <= win + 2'd1;
                glb_addr <= sel_addr;
            end
            // Write data is only refreshed by writes; reads leave it alone.
            if (gnt_ok && (win == ID_OPSUM)) begin
                glb_wdata <= opsum_wdata;
            end
        end
    end

    // Return pipeline: stage k is valid in cycle grant+1+k. The last stage
    // coincides with glb_rdata being valid, so rdata/rvalid appear one cycle
    // later from their own registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int k = 0; k < NSTG; k++) begin
                pipe_id[k] <= 2'd0;
            end
            rvalid_q <= 4'b0000;
            rdata    <= '0;
        end else begin
            pipe_vld[0] <= gnt_ok && (win != ID_OPSUM);
            pipe_id[0]  <= win;
            for (int k = 1; k < NSTG; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_id[k]  <= pipe_id[k-1];
            end
            rvalid_q <= 4'b0000;
            if (pipe_vld[NSTG-1]) begin
                rvalid_q[pipe_id[NSTG-1]] <= 1'b1;
                rdata                     <= glb_rdata;
            end
        end
    end

    assign ifmap_rvalid  = rvalid_q[0];
    assign filter_rvalid = rvalid_q[1];
    assign ipsum_rvalid  = rvalid_q[2];

    assign busy = glb_en | (|pipe_vld);

endmodule

// File: tb/tb_glb_port_arbiter.sv
module tb_glb_port_arbiter;

    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int MAXC = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          ifmap_req, filter_req, ipsum_req, opsum_req;
    logic [AW-1:0] ifmap_addr, filter_addr, ipsum_addr, opsum_addr;
    logic [DW-1:0] opsum_wdata, glb_rdata;

    logic [3:0]    gnt1, gnt3;
    logic [2:0]    rv1, rv3;
    logic [DW-1:0] rdata1, rdata3, wd1, wd3;
    logic [AW-1:0] ad1, ad3;
    logic          en1, en3, we1, we3, busy1, busy3;

    always #5 clk = ~clk;

    glb_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u1 (
        .clk(clk), .reset(reset),
        .ifmap_req(ifmap_req), .ifmap_addr(ifmap_addr), .ifmap_gnt(gnt1[0]), .ifmap_rvalid(rv1[0]),
        .filter_req(filter_req), .filter_addr(filter_addr), .filter_gnt(gnt1[1]), .filter_rvalid(rv1[1]),
        .ipsum_req(ipsum_req), .ipsum_addr(ipsum_addr), .ipsum_gnt(gnt1[2]), .ipsum_rvalid(rv1[2]),
        .opsum_req(opsum_req), .opsum_addr(opsum_addr), .opsum_wdata(opsum_wdata), .opsum_gnt(gnt1[3]),
        .rdata(rdata1), .glb_en(en1), .glb_we(we1), .glb_addr(ad1), .glb_wdata(wd1),
        .glb_rdata(glb_rdata), .busy(busy1)
    );

    glb_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) u3 (
        .clk(clk), .reset(reset),
        .ifmap_req(ifmap_req), .ifmap_addr(ifmap_addr), .ifmap_gnt(gnt3[0]), .ifmap_rvalid(rv3[0]),
        .filter_req(filter_req), .filter_addr(filter_addr), .filter_gnt(gnt3[1]), .filter_rvalid(rv3[1]),
        .ipsum_req(ipsum_req), .ipsum_addr(ipsum_addr), .ipsum_gnt(gnt3[2]), .ipsum_rvalid(rv3[2]),
        .opsum_req(opsum_req), .opsum_addr(opsum_addr), .opsum_wdata(opsum_wdata), .opsum_gnt(gnt3[3]),
        .rdata(rdata3), .glb_en(en3), .glb_we(we3), .glb_addr(ad3), .glb_wdata(wd3),
        .glb_rdata(glb_rdata), .busy(busy3)
    );

    int errs   = 0;
    int checks = 0;

    // Requester side: each stream walks its own address sequence.
    logic [AW-1:0] base [4] = '{20'h00010, 20'hF0000, 20'hABC00, 20'h00100};
    int            cnt  [4];

    // History of what happened in each cycle (model input).
    int            g_id  [MAXC];
    logic [AW-1:0] g_addr[MAXC];
    logic [DW-1:0] g_wd  [MAXC];
    logic [DW-1:0] rd_h  [MAXC];
    bit            rst_h [MAXC];

    // Observations kept for the literal checks.
    int            ob_gnt [MAXC];
    logic [2:0]    ob_rv1 [MAXC];
    logic [2:0]    ob_rv3 [MAXC];
    logic [DW-1:0] ob_rd1 [MAXC];
    logic [DW-1:0] ob_rd3 [MAXC];
    logic [AW-1:0] ob_addr[MAXC];
    logic [DW-1:0] ob_wd  [MAXC];
    logic          ob_en  [MAXC];
    logic          ob_we  [MAXC];
    logic          ob_b1  [MAXC];
    logic          ob_b3  [MAXC];

    int            cyc  = 0;
    int            mptr = 0;
    logic [DW-1:0] erd1, erd3, ewd;
    logic [AW-1:0] eaddr;

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, t, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int s);
        return base[s] + AW'(cnt[s]);
    endfunction

    function automatic logic [DW-1:0] rv();
        return 16'h5A00 ^ DW'(cyc * 37);
    endfunction

    function automatic logic [3:0] onehot4(input int id);
        logic [3:0] v;
        v = 4'b0000;
        if (id >= 0) v[id] = 1'b1;
        return v;
    endfunction

    function automatic bit no_rst(input int a, input int b);
        for (int k = a; k <= b; k++)
            if (k >= 0 && rst_h[k]) return 1'b0;
        return 1'b1;
    endfunction

    // Read granted in N returns with rvalid in N+L+2, unless reset is seen in between.
    function automatic int exp_rv(input int lat, input int t);
        int n;
        n = t - lat - 2;
        if (n < 0) return -1;
        if (g_id[n] >= 0 && g_id[n] < 3 && no_rst(n + 1, t - 1)) return g_id[n];
        return -1;
    endfunction

    // A read granted in N keeps the port busy for cycles N+1 .. N+L+1; a write only for N+1.
    function automatic bit exp_busy(input int lat, input int t);
        for (int n = t - lat - 1; n <= t - 1; n++) begin
            if (n >= 0) begin
                if (n == t - 1 && g_id[n] >= 0) return 1'b1;
                if (g_id[n] >= 0 && g_id[n] < 3 && no_rst(n + 1, t - 1)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic cycle(input logic [3:0] rq, input logic rst, input logic [DW-1:0] rd);
        int            gid, t, r1, r3, j;
        logic          en_e;
        logic [AW-1:0] cur [4];
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) cur[s] = addr_of(s);
        reset       = rst;
        ifmap_req   = rq[0];
        filter_req  = rq[1];
        ipsum_req   = rq[2];
        opsum_req   = rq[3];
        ifmap_addr  = cur[0];
        filter_addr = cur[1];
        ipsum_addr  = cur[2];
        opsum_addr  = cur[3];
        opsum_wdata = 16'h1234 + DW'(cnt[3]);
        glb_rdata   = rd;
        @(negedge clk);
        t = cyc;

        gid = -1;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                j = (mptr + i) % 4;
                if (gid < 0 && rq[j]) gid = j;
            end
        end
        chk("gnt_l1", t, 32'(gnt1), 32'(onehot4(gid)));
        chk("gnt_l3", t, 32'(gnt3), 32'(onehot4(gid)));

        if (t >= 1) begin
            en_e = (g_id[t-1] >= 0);
            if (rst_h[t-1]) begin
                eaddr = '0; ewd = '0; erd1 = '0; erd3 = '0;
            end else begin
                if (en_e) eaddr = g_addr[t-1];
                if (g_id[t-1] == 3) ewd = g_wd[t-1];
            end
            r1 = exp_rv(1, t);
            r3 = exp_rv(3, t);
            if (r1 >= 0) erd1 = rd_h[t-1];
            if (r3 >= 0) erd3 = rd_h[t-1];

            chk("glb_en_l1", t, 32'(en1), 32'(en_e));
            chk("glb_en_l3", t, 32'(en3), 32'(en_e));
            chk("glb_we_l1", t, 32'(we1), 32'(en_e && g_id[t-1] == 3));
            chk("glb_we_l3", t, 32'(we3), 32'(en_e && g_id[t-1] == 3));
            if (en_e || rst_h[t-1]) begin
                chk("glb_addr_l1", t, 32'(ad1), 32'(eaddr));
                chk("glb_addr_l3", t, 32'(ad3), 32'(eaddr));
            end
            chk("glb_wdata_l1", t, 32'(wd1), 32'(ewd));
            chk("glb_wdata_l3", t, 32'(wd3), 32'(ewd));
            chk("rvalid_l1", t, 32'(rv1), 32'(onehot4(r1)));
            chk("rvalid_l3", t, 32'(rv3), 32'(onehot4(r3)));
            chk("rdata_l1", t, 32'(rdata1), 32'(erd1));
            chk("rdata_l3", t, 32'(rdata3), 32'(erd3));
            chk("busy_l1", t, 32'(busy1), 32'(exp_busy(1, t)));
            chk("busy_l3", t, 32'(busy3), 32'(exp_busy(3, t)));
        end

        case (gnt1)
            4'b0000: ob_gnt[t] = -1;
            4'b0001: ob_gnt[t] = 0;
            4'b0010: ob_gnt[t] = 1;
            4'b0100: ob_gnt[t] = 2;
            4'b1000: ob_gnt[t] = 3;
            default: ob_gnt[t] = -2;
        endcase
        ob_rv1[t] = rv1;  ob_rv3[t] = rv3;
        ob_rd1[t] = rdata1; ob_rd3[t] = rdata3;
        ob_addr[t] = ad1; ob_wd[t] = wd1;
        ob_en[t] = en1;   ob_we[t] = we1;
        ob_b1[t] = busy1; ob_b3[t] = busy3;

        g_id[t]   = gid;
        g_addr[t] = (gid >= 0) ? cur[gid] : '0;
        g_wd[t]   = opsum_wdata;
        rst_h[t]  = rst;
        rd_h[t]   = rd;
        if (rst) mptr = 0;
        else if (gid >= 0) begin
            mptr = (gid + 1) % 4;
            cnt[gid]++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'b0000, 1'b0, rv());
    endtask

    initial begin
        int p, pulses1, pulses3;
        int exp4 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        reset = 1'b1;
        ifmap_req = 0; filter_req = 0; ipsum_req = 0; opsum_req = 0;
        ifmap_addr = '0; filter_addr = '0; ipsum_addr = '0; opsum_addr = '0;
        opsum_wdata = '0; glb_rdata = '0;
        erd1 = '0; erd3 = '0; ewd = '0; eaddr = '0;
        for (int s = 0; s < 4; s++) cnt[s] = 0;
        for (int k = 0; k < MAXC; k++) begin
            g_id[k] = -1; rst_h[k] = 1'b0;
        end

        // Reset, with requests asserted during reset ignored.
        cycle(4'b0000, 1'b1, rv());
        cycle(4'b1111, 1'b1, rv());
        chk("lit_reset_gnt", 1, 32'(ob_gnt[1]), 32'hFFFFFFFF);
        chk("lit_reset_en", 1, 32'(ob_en[1]), 32'd0);
        chk("lit_reset_rdata", 1, 32'(ob_rd1[1]), 32'd0);

        // All four held for 8 cycles from reset.
        p = cyc;
        for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b0, rv());
        idle(8);
        for (int i = 0; i < 8; i++) chk("lit_rr4_order", p + i, 32'(ob_gnt[p+i]), 32'(exp4[i]));
        for (int k = 1; k <= 8; k++) chk("lit_rr4_we", p + k, 32'(ob_we[p+k]), 32'(k == 4 || k == 8));
        pulses1 = 0; pulses3 = 0;
        for (int k = p; k < p + 16; k++) begin
            pulses1 += $countones(ob_rv1[k]);
            pulses3 += $countones(ob_rv3[k]);
        end
        chk("lit_rr4_pulses_l1", p, 32'(pulses1), 32'd6);
        chk("lit_rr4_pulses_l3", p, 32'(pulses3), 32'd6);

        // Fresh reset, then a lone opsum write.
        for (int s = 0; s < 4; s++) cnt[s] = 0;
        cycle(4'b0000, 1'b1, rv());
        p = cyc;
        cycle(4'b1000, 1'b0, rv());
        idle(6);
        chk("lit_wr_en", p + 1, 32'(ob_en[p+1]), 32'd1);
        chk("lit_wr_we", p + 1, 32'(ob_we[p+1]), 32'd1);
        chk("lit_wr_addr", p + 1, 32'(ob_addr[p+1]), 32'h00100);
        chk("lit_wr_wdata", p + 1, 32'(ob_wd[p+1]), 32'h1234);
        chk("lit_wr_busy_l1", p + 2, 32'(ob_b1[p+2]), 32'd0);
        chk("lit_wr_busy_l3", p + 2, 32'(ob_b3[p+2]), 32'd0);
        for (int k = p; k < p + 7; k++) chk("lit_wr_no_rvalid", k, 32'(ob_rv1[k] | ob_rv3[k]), 32'd0);

        // Single ifmap read, RD_LATENCY=1.
        p = cyc;
        cycle(4'b0001, 1'b0, rv());
        cycle(4'b0000, 1'b0, rv());
        cycle(4'b0000, 1'b0, 16'hBEEF);
        idle(4);
        chk("lit_rd_gnt", p, 32'(ob_gnt[p]), 32'd0);
        chk("lit_rd_en", p + 1, 32'(ob_en[p+1]), 32'd1);
        chk("lit_rd_we", p + 1, 32'(ob_we[p+1]), 32'd0);
        chk("lit_rd_addr", p + 1, 32'(ob_addr[p+1]), 32'h00010);
        chk("lit_rd_rv_early", p + 2, 32'(ob_rv1[p+2]), 32'd0);
        chk("lit_rd_rv", p + 3, 32'(ob_rv1[p+3]), 32'b001);
        chk("lit_rd_rdata", p + 3, 32'(ob_rd1[p+3]), 32'hBEEF);
        chk("lit_rd_rv_late", p + 4, 32'(ob_rv1[p+4]), 32'd0);
        chk("lit_rd_busy1", p + 1, 32'(ob_b1[p+1]), 32'd1);
        chk("lit_rd_busy2", p + 2, 32'(ob_b1[p+2]), 32'd1);
        chk("lit_rd_busy3", p + 3, 32'(ob_b1[p+3]), 32'd0);
        chk("lit_rd_busy4", p + 4, 32'(ob_b1[p+4]), 32'd0);

        // filter and ipsum held continuously, pointer at filter.
        p = cyc;
        for (int i = 0; i < 6; i++) cycle(4'b0110, 1'b0, rv());
        idle(6);
        for (int i = 0; i < 6; i++) chk("lit_alt_order", p + i, 32'(ob_gnt[p+i]), 32'(1 + (i % 2)));

        // ipsum read with RD_LATENCY=3.
        p = cyc;
        cycle(4'b0100, 1'b0, rv());
        idle(3);
        cycle(4'b0000, 1'b0, 16'hC0DE);
        idle(3);
        chk("lit_l3_gnt", p, 32'(ob_gnt[p]), 32'd2);
        chk("lit_l3_rv_early", p + 4, 32'(ob_rv3[p+4]), 32'd0);
        chk("lit_l3_rv", p + 5, 32'(ob_rv3[p+5]), 32'b100);
        chk("lit_l3_rdata", p + 5, 32'(ob_rd3[p+5]), 32'hC0DE);

        // Two reads in flight, reset lands on top of them.
        p = cyc;
        cycle(4'b0001, 1'b0, rv());
        cycle(4'b0010, 1'b0, rv());
        cycle(4'b0100, 1'b1, rv());
        cycle(4'b0101, 1'b0, rv());
        cycle(4'b0100, 1'b0, rv());
        idle(8);
        chk("lit_mr_rst_gnt", p + 2, 32'(ob_gnt[p+2]), 32'hFFFFFFFF);
        chk("lit_mr_en", p + 3, 32'(ob_en[p+3]), 32'd0);
        chk("lit_mr_addr", p + 3, 32'(ob_addr[p+3]), 32'd0);
        chk("lit_mr_busy", p + 3, 32'(ob_b1[p+3]), 32'd0);
        chk("lit_mr_rdata", p + 3, 32'(ob_rd1[p+3]), 32'd0);
        chk("lit_mr_next_gnt", p + 3, 32'(ob_gnt[p+3]), 32'd0);
        for (int k = p + 3; k <= p + 4; k++) chk("lit_mr_no_rv_l1", k, 32'(ob_rv1[k]), 32'd0);
        for (int k = p + 3; k <= p + 6; k++) chk("lit_mr_no_rv_l3", k, 32'(ob_rv3[k]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
